// File: rtl/calc_mem_responder.sv
// Word memory serving the calculator controller's read/write strobes plus a lower-priority host
// port, with a fixed read latency, a sticky out-of-range flag and saturating access counters.
module calc_mem_responder #(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned MEM_WORD_SIZE = 64,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned RD_LAT        = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        r_addr,
    output logic [MEM_WORD_SIZE-1:0] r_data,
    output logic                     r_valid,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [MEM_WORD_SIZE-1:0] w_data,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDR_W-1:0]        host_addr,
    input  logic [MEM_WORD_SIZE-1:0] host_wdata,
    output logic                     host_gnt,
    output logic [MEM_WORD_SIZE-1:0] host_rdata,
    output logic                     host_rvalid,
    output logic                     addr_err,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MEM_WORD_SIZE-1:0] mem_q [DEPTH];

    logic                     r_valid_q, host_rvalid_q, addr_err_q, addr_err_d;
    logic [MEM_WORD_SIZE-1:0] r_data_q, host_rdata_q;
    logic [15:0]              rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    logic                     host_rd;
    logic                     c_fin_vld, h_fin_vld;
    logic [ADDR_W-1:0]        c_fin_addr, h_fin_addr;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 64'(addr) < 64'(DEPTH);
    endfunction

    function automatic logic [MEM_WORD_SIZE-1:0] rd_word(input logic [ADDR_W-1:0] addr);
        return in_range(addr) ? mem_q[addr[IdxW-1:0]] : '0;
    endfunction

    assign host_gnt = host_req & ~read & ~write;
    assign host_rd  = host_gnt & ~host_we;

    // The array is sampled at the edge ending the last stage, so with RD_LAT=1 the request
    // itself is the final stage and the read sees the pre-write contents of that edge.
    if (RD_LAT > 1) begin : g_pipe
        logic [RD_LAT-2:0] c_vld_q, h_vld_q;
        logic [ADDR_W-1:0] c_addr_q [RD_LAT-1];
        logic [ADDR_W-1:0] h_addr_q [RD_LAT-1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                c_vld_q <= '0;
                h_vld_q <= '0;
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    c_addr_q[i] <= '0;
                    h_addr_q[i] <= '0;
                end
            end else begin
                c_vld_q[0]  <= read;
                c_addr_q[0] <= r_addr;
                h_vld_q[0]  <= host_rd;
                h_addr_q[0] <= host_addr;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    c_vld_q[i]  <= c_vld_q[i-1];
                    c_addr_q[i] <= c_addr_q[i-1];
                    h_vld_q[i]  <= h_vld_q[i-1];
                    h_addr_q[i] <= h_addr_q[i-1];
                end
            end
        end

        assign c_fin_vld  = c_vld_q[RD_LAT-2];
        assign c_fin_addr = c_addr_q[RD_LAT-2];
        assign h_fin_vld  = h_vld_q[RD_LAT-2];
        assign h_fin_addr = h_addr_q[RD_LAT-2];
    end else begin : g_nopipe
        assign c_fin_vld  = read;
        assign c_fin_addr = r_addr;
        assign h_fin_vld  = host_rd;
        assign h_fin_addr = host_addr;
    end

    // Host grant already excludes controller writes, so a single write port suffices.
    always_ff @(posedge clk_i) begin
        if (write) begin
            if (in_range(w_addr)) mem_q[w_addr[IdxW-1:0]] <= w_data;
        end else if (host_gnt && host_we && in_range(host_addr)) begin
            mem_q[host_addr[IdxW-1:0]] <= host_wdata;
        end
    end

    always_comb begin
        addr_err_d = addr_err_q
                   | (read     & ~in_range(r_addr))
                   | (write    & ~in_range(w_addr))
                   | (host_gnt & ~in_range(host_addr));
        rd_cnt_d = rd_cnt_q;
        if (read && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        wr_cnt_d = wr_cnt_q;
        if (write && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data_q      <= '0;
            r_valid_q     <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
        end else begin
            r_valid_q     <= c_fin_vld;
            host_rvalid_q <= h_fin_vld;
            if (c_fin_vld) r_data_q <= rd_word(c_fin_addr);
            if (h_fin_vld) host_rdata_q <= rd_word(h_fin_addr);
            addr_err_q    <= addr_err_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
        end
    end

    assign r_data      = r_data_q;
    assign r_valid     = r_valid_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign addr_err    = addr_err_q;
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_calc_mem_responder.sv
// Directed bench: one instance at RD_LAT=1 (ADDR_W=11, DEPTH=1024) and one at RD_LAT=3.
module tb_calc_mem_responder;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_n, rst3_n;

    logic        read, write, host_req, host_we, host_gnt, r_valid, host_rvalid, addr_err;
    logic [10:0] r_addr, w_addr, host_addr;
    logic [63:0] w_data, host_wdata, r_data, host_rdata;
    logic [15:0] rd_count, wr_count;

    logic        read3, write3, host_req3, host_we3, host_gnt3, r_valid3, host_rvalid3, addr_err3;
    logic [9:0]  r_addr3, w_addr3, host_addr3;
    logic [63:0] w_data3, host_wdata3, r_data3, host_rdata3;
    logic [15:0] rd_count3, wr_count3;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    localparam logic [63:0] W0 = 64'h0000_0005_0000_0003;
    localparam logic [63:0] W3 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] WD = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] A1 = 64'h0000_0011_0000_00A1;
    localparam logic [63:0] A2 = 64'h0000_0022_0000_00A2;
    localparam logic [63:0] A3 = 64'h0000_0033_0000_00A3;

    calc_mem_responder #(
        .ADDR_W(11), .MEM_WORD_SIZE(64), .DEPTH(1024), .RD_LAT(1)
    ) u_dut (
        .clk_i(clk_i), .rst_ni(rst_n),
        .read(read), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
        .write(write), .w_addr(w_addr), .w_data(w_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .addr_err(addr_err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    calc_mem_responder #(
        .ADDR_W(10), .MEM_WORD_SIZE(64), .DEPTH(16), .RD_LAT(3)
    ) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst3_n),
        .read(read3), .r_addr(r_addr3), .r_data(r_data3), .r_valid(r_valid3),
        .write(write3), .w_addr(w_addr3), .w_data(w_data3),
        .host_req(host_req3), .host_we(host_we3), .host_addr(host_addr3),
        .host_wdata(host_wdata3), .host_gnt(host_gnt3), .host_rdata(host_rdata3),
        .host_rvalid(host_rvalid3), .addr_err(addr_err3),
        .rd_count(rd_count3), .wr_count(wr_count3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int unsigned vcnt;
        rst_n = 1'b0; rst3_n = 1'b0;
        read = 0; write = 0; host_req = 0; host_we = 0;
        r_addr = '0; w_addr = '0; host_addr = '0; w_data = '0; host_wdata = '0;
        read3 = 0; write3 = 0; host_req3 = 0; host_we3 = 0;
        r_addr3 = '0; w_addr3 = '0; host_addr3 = '0; w_data3 = '0; host_wdata3 = '0;
        step(); step();

        check("rst_r_data", r_data, 64'd0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_host_rdata", host_rdata, 64'd0);
        check("rst_host_rvalid", host_rvalid, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_rd_count", rd_count, 16'd0);
        check("rst_wr_count", wr_count, 16'd0);
        check("rst3_r_data", r_data3, 64'd0);
        rst_n = 1'b1; rst3_n = 1'b1;

        // Host preload of words 0, 7 and 3
        host_req = 1; host_we = 1; host_addr = 11'd0; host_wdata = W0;
        #1 check("host_gnt_idle", host_gnt, 1'b1);
        step();
        host_addr = 11'd7; host_wdata = 64'd0; step();
        host_addr = 11'd3; host_wdata = W3;    step();
        host_req = 0; host_we = 0;

        read = 1; r_addr = 11'd0; step(); read = 0;
        check("rd0_valid", r_valid, 1'b1);
        check("rd0_data", r_data, W0);
        step();
        check("rd0_valid_drop", r_valid, 1'b0);
        check("rd0_data_hold", r_data, W0);

        // Same-address read and write: old data first, new data on the re-read
        write = 1; w_addr = 11'd7; w_data = WD; read = 1; r_addr = 11'd7;
        host_req = 1; host_we = 1; host_addr = 11'd9; host_wdata = '1;
        #1 check("host_gnt_vs_write", host_gnt, 1'b0);
        step();
        write = 0; host_req = 0; host_we = 0;
        check("rbw_old_data", r_data, 64'd0);
        check("rbw_valid", r_valid, 1'b1);
        step(); read = 0;
        check("rbw_new_data", r_data, WD);

        // Host read held off by three controller reads
        host_req = 1; host_we = 0; host_addr = 11'd3; read = 1; r_addr = 11'd0;
        for (int i = 0; i < 3; i++) begin
            #1 check("host_gnt_blocked", host_gnt, 1'b0);
            step();
        end
        read = 0;
        #1 check("host_gnt_free", host_gnt, 1'b1);
        step(); host_req = 0;
        check("host_rvalid", host_rvalid, 1'b1);
        check("host_rdata", host_rdata, W3);
        step();
        check("host_rvalid_drop", host_rvalid, 1'b0);
        check("host_rdata_hold", host_rdata, W3);
        check("rd_count_6", rd_count, 16'd6);
        check("wr_count_1", wr_count, 16'd1);
        check("addr_err_clean", addr_err, 1'b0);

        // Out-of-range write is dropped but counted; out-of-range read returns zero
        write = 1; w_addr = 11'd1024; w_data = 64'hBAD0_BAD0_BAD0_BAD0; step(); write = 0;
        check("oor_addr_err", addr_err, 1'b1);
        check("oor_wr_count", wr_count, 16'd2);
        read = 1; r_addr = 11'd0; step();
        check("oor_no_alias", r_data, W0);
        r_addr = 11'd1024; step(); read = 0;
        check("oor_rd_data", r_data, 64'd0);
        check("oor_rd_valid", r_valid, 1'b1);
        check("oor_err_sticky", addr_err, 1'b1);
        check("rd_count_8", rd_count, 16'd8);

        // Saturation: 8 + 65526 = 16'hFFFE, then three more reads
        read = 1; r_addr = 11'd0;
        repeat (65526) @(posedge clk_i);
        #1 check("rd_count_fffe", rd_count, 16'hFFFE);
        repeat (3) step();
        read = 0;
        check("rd_count_sat", rd_count, 16'hFFFF);
        step();
        check("rd_count_hold", rd_count, 16'hFFFF);
        check("wr_count_unchanged", wr_count, 16'd2);

        // RD_LAT=3 instance: preload via host
        host_req3 = 1; host_we3 = 1; host_addr3 = 10'd1; host_wdata3 = A1; step();
        host_addr3 = 10'd2; host_wdata3 = A2; step();
        host_addr3 = 10'd3; host_wdata3 = A3; step();
        host_we3 = 0; host_addr3 = 10'd2; step();
        host_req3 = 0;
        check("l3_host_rvalid_c1", host_rvalid3, 1'b0);
        step();
        check("l3_host_rvalid_c2", host_rvalid3, 1'b0);
        step();
        check("l3_host_rvalid_c3", host_rvalid3, 1'b1);
        check("l3_host_rdata", host_rdata3, A2);

        read3 = 1; r_addr3 = 10'd1; step();
        check("l3_rvalid_n1", r_valid3, 1'b0);
        r_addr3 = 10'd2; step();
        check("l3_rvalid_n2", r_valid3, 1'b0);
        r_addr3 = 10'd3; step(); read3 = 0;
        check("l3_rvalid_n3", r_valid3, 1'b1);
        check("l3_rdata_n3", r_data3, A1);
        step();
        check("l3_rdata_n4", r_data3, A2);
        step();
        check("l3_rdata_n5", r_data3, A3);
        step();
        check("l3_rvalid_n6", r_valid3, 1'b0);
        check("l3_rdata_hold", r_data3, A3);

        // Reset with reads in flight discards them
        read3 = 1; r_addr3 = 10'd1; step();
        r_addr3 = 10'd2; step();
        r_addr3 = 10'd3;
        #2 rst3_n = 1'b0;
        #1 check("l3_rst_rdata", r_data3, 64'd0);
        check("l3_rst_rvalid", r_valid3, 1'b0);
        step(); step();
        rst3_n = 1'b1; read3 = 0;
        vcnt = 0;
        repeat (6) begin
            step();
            if (r_valid3) vcnt++;
        end
        check("l3_no_valid_after_rst", vcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
